// File: rtl/brc_iter.sv
`default_nettype none
// ============================================================================
// Module   : brc_iter
// Purpose  : Iterative branch comparator. Compares two WIDTH-bit operands
//            CHUNK bits per cycle, most-significant chunk first. It stops as
//            soon as a chunk differs, so latency depends on the data.
//            Supports signed and unsigned compares.
// Ports    : i_clk, i_rst          - clock, asynchronous active-high reset
//            i_valid / o_ready     - request handshake
//            i_rs1_data/i_rs2_data - operands A and B
//            i_br_un               - 1 = unsigned compare, 0 = signed compare
//            i_kill                - abort the in-flight compare
//            o_valid / i_ready     - result handshake
//            o_br_less/o_br_equal  - registered results (A < B, A == B)
// Revision : 1.0 - initial release
// ============================================================================
module brc_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_br_un,
    input  logic             i_kill,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal
);

    localparam int N  = WIDTH / CHUNK;
    localparam int JW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_un;
    logic [JW-1:0]    r_j;
    logic [JW-1:0]    w_j_nxt;
    logic             r_less;
    logic             r_equal;
    logic             w_less_nxt;
    logic             w_equal_nxt;
    logic             w_load;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic             w_chunk_less;

    // Chunk j covers the j-th CHUNK-wide slice counted down from the MSB.
    assign w_a_chunk = r_a[(WIDTH-1) - int'(r_j)*CHUNK -: CHUNK];
    assign w_b_chunk = r_b[(WIDTH-1) - int'(r_j)*CHUNK -: CHUNK];

    // Only the top chunk carries the sign bit. Once the upper chunks are
    // equal, the lower chunks order the same way for signed and unsigned.
    always_comb begin
        if ((r_j == '0) && !r_un) begin
            w_chunk_less = $signed(w_a_chunk) < $signed(w_b_chunk);
        end else begin
            w_chunk_less = w_a_chunk < w_b_chunk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_less_nxt  = r_less;
        w_equal_nxt = r_equal;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_valid && !i_kill) begin
                    w_load      = 1'b1;
                    w_j_nxt     = '0;
                    w_state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                if (i_kill) begin
                    w_state_nxt = S_IDLE;
                end else if (w_a_chunk != w_b_chunk) begin
                    w_less_nxt  = w_chunk_less;
                    w_equal_nxt = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (r_j == JW'(N-1)) begin
                    w_less_nxt  = 1'b0;
                    w_equal_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_j_nxt = r_j + JW'(1);
                end
            end
            S_DONE: begin
                // A kill also returns to IDLE. It takes priority over
                // consumption, but both paths end in IDLE.
                if (i_kill || i_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_j     <= '0;
            r_less  <= 1'b0;
            r_equal <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_un    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_less  <= w_less_nxt;
            r_equal <= w_equal_nxt;
            if (w_load) begin
                r_a  <= i_rs1_data;
                r_b  <= i_rs2_data;
                r_un <= i_br_un;
            end
        end
    end

    // o_ready is gated by reset directly so it drops at once while reset is held.
    assign o_ready    = (r_state == S_IDLE) && !i_rst;
    assign o_valid    = (r_state == S_DONE);
    assign o_br_less  = r_less;
    assign o_br_equal = r_equal;

endmodule
`default_nettype wire
